mem_stage: RTL and testbench

- Memory-access stage of the 5-stage 32-bit pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM register outputs: WB control, read/write enables, branch flag, zero flag, ALU address, store data and destination register.
- Performs data-memory load/store against an internal word-addressed RAM with configurable access latency, and resolves branches.
- Owns the MEM/WB pipeline register that feeds write-back and the forwarding unit.

---
 rtl/mem_stage.sv | 99 +++++++++
 tb/tb_mem_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: word-addressed data RAM with optional multi-cycle access,
// branch resolution, and the MEM/WB pipeline register feeding write-back.
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Mem_WB,
  input  logic        read_En,
  input  logic        write_En,
  input  logic        Mem_Br,
  input  logic        Zero,
  input  logic [31:0] DataAddress,
  input  logic [31:0] WriteData,
  input  logic [4:0]  dest,
  output logic [1:0]  WB_ctrl,
  output logic [31:0] ReadData,
  output logic [31:0] ALUResult,
  output logic [4:0]  Write_Register,
  output logic        PCSrc,
  output logic        stall
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              access;
  logic              commit;
  logic              bubble;

  // Byte offset and high address bits are dropped, so addresses wrap modulo depth.
  assign idx    = DataAddress[ADDR_W+1:2];
  assign access = read_En | write_En;

  generate
    if (MEM_LATENCY == 0) begin : g_single
      assign commit = access;
      assign bubble = 1'b0;
    end else begin : g_multi
      state_t     state_reg;
      logic [3:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (access) begin
                state_reg <= BUSY;
                cnt_reg   <= 4'(MEM_LATENCY - 1);
              end
            end
            BUSY: begin
              if (cnt_reg == 4'd0) state_reg <= IDLE;
              else                 cnt_reg   <= cnt_reg - 4'd1;
            end
            default: state_reg <= IDLE;
          endcase
        end
      end

      // The access commits only on the last cycle of BUSY; every earlier cycle is a bubble.
      assign commit = (state_reg == BUSY) && (cnt_reg == 4'd0);
      assign bubble = (state_reg == IDLE) ? access : (cnt_reg != 4'd0);
    end
  endgenerate

  assign stall = bubble & ~rst;
  assign PCSrc = Mem_Br & Zero & ~rst;

  // Gating with rst keeps an aborted store from ever reaching the array.
  always_ff @(posedge clk) begin
    if (commit && write_En && !rst) ram[idx] <= WriteData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_ctrl        <= '0;
      ReadData       <= '0;
      ALUResult      <= '0;
      Write_Register <= '0;
    end else if (bubble) begin
      WB_ctrl <= '0;
    end else begin
      WB_ctrl        <= Mem_WB;
      ALUResult      <= DataAddress;
      Write_Register <= dest;
      // Non-blocking read alongside the write gives read-before-write on collision.
      if (commit && read_En) ReadData <= ram[idx];
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: one single-cycle instance and one 3-wait-state instance.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  wb;
    logic        rd;
    logic        wr;
    logic        br;
    logic        z;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  dest;
  } in_t;

  typedef struct {
    logic [1:0]  wb;
    logic [4:0]  dest;
    logic [31:0] addr;
    bit          chk;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  logic        rst_a, rst_b;
  in_t         in_a, in_b;
  logic [1:0]  wb_a, wb_b;
  logic [31:0] rdata_a, rdata_b, alu_a, alu_b;
  logic [4:0]  wreg_a, wreg_b;
  logic        pcsrc_a, pcsrc_b, stall_a, stall_b;

  exp_t q_a[$];
  exp_t q_b[$];
  bit   vld_a, vld_b;
  int   tests, fails;

  mem_stage #(.ADDR_W(8), .MEM_LATENCY(0)) dut_a (
    .clk(clk), .rst(rst_a), .Mem_WB(in_a.wb), .read_En(in_a.rd), .write_En(in_a.wr),
    .Mem_Br(in_a.br), .Zero(in_a.z), .DataAddress(in_a.addr), .WriteData(in_a.wdata),
    .dest(in_a.dest), .WB_ctrl(wb_a), .ReadData(rdata_a), .ALUResult(alu_a),
    .Write_Register(wreg_a), .PCSrc(pcsrc_a), .stall(stall_a)
  );

  mem_stage #(.ADDR_W(8), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst_b), .Mem_WB(in_b.wb), .read_En(in_b.rd), .write_En(in_b.wr),
    .Mem_Br(in_b.br), .Zero(in_b.z), .DataAddress(in_b.addr), .WriteData(in_b.wdata),
    .dest(in_b.dest), .WB_ctrl(wb_b), .ReadData(rdata_b), .ALUResult(alu_b),
    .Write_Register(wreg_b), .PCSrc(pcsrc_b), .stall(stall_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT retires an instruction.
  task automatic run_mon(input bit b);
    bit   pend, bub;
    int   ns;
    exp_t e;
    string tag;
    tag = b ? "b" : "a";
    ns  = 0;
    forever begin
      @(negedge clk);
      pend = (b ? vld_b : vld_a) && !(b ? stall_b : stall_a) && !(b ? rst_b : rst_a);
      bub  = (b ? vld_b : vld_a) &&  (b ? stall_b : stall_a) && !(b ? rst_b : rst_a);
      @(posedge clk);
      #1;
      if (bub) begin
        ns++;
        chk({tag, "_bubble_wb"}, 32'(b ? wb_b : wb_a), 32'd0);
      end else if (pend) begin
        if ((b ? q_b.size() : q_a.size()) == 0) begin
          tests++;
          fails++;
          $display("FAIL %s_unexpected_output: got output expected none", tag);
        end else begin
          e = b ? q_b.pop_front() : q_a.pop_front();
          chk({tag, "_wb_ctrl"}, 32'(b ? wb_b : wb_a), 32'(e.wb));
          chk({tag, "_write_reg"}, 32'(b ? wreg_b : wreg_a), 32'(e.dest));
          chk({tag, "_alu_result"}, b ? alu_b : alu_a, e.addr);
          chk({tag, "_stall_cycles"}, 32'(ns), 32'(e.stalls));
          if (e.chk) chk({tag, "_read_data"}, b ? rdata_b : rdata_a, e.rdata);
          $display("[TB] %s txn dest=%0d wb=%b addr=%h rdata=%h stalls=%0d", tag,
                   b ? wreg_b : wreg_a, b ? wb_b : wb_a, b ? alu_b : alu_a,
                   b ? rdata_b : rdata_a, ns);
        end
        ns = 0;
      end
    end
  endtask

  initial run_mon(1'b0);
  initial run_mon(1'b1);

  // Driver: present one instruction at posedge+1 and hold it until stall drops.
  task automatic issue(input bit b, input logic [1:0] wb, input logic rd, input logic wr,
                       input logic br, input logic z, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] dest, input bit chk_rd,
                       input logic [31:0] exp_rd, input int stalls, input logic exp_pc);
    in_t  v;
    exp_t e;
    int   n;
    v.wb = wb; v.rd = rd; v.wr = wr; v.br = br; v.z = z;
    v.addr = addr; v.wdata = wdata; v.dest = dest;
    e.wb = wb; e.dest = dest; e.addr = addr; e.chk = chk_rd; e.rdata = exp_rd; e.stalls = stalls;
    if (b) begin in_b = v; vld_b = 1'b1; q_b.push_back(e); end
    else   begin in_a = v; vld_a = 1'b1; q_a.push_back(e); end
    #1;
    chk(b ? "b_pcsrc" : "a_pcsrc", 32'(b ? pcsrc_b : pcsrc_a), 32'(exp_pc));
    n = 0;
    forever begin
      @(negedge clk);
      if (!(b ? stall_b : stall_a)) break;
      n++;
      if (n > 40) begin
        tests++;
        fails++;
        $display("FAIL stall_timeout: got stall held %0d cycles expected release", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (b) begin in_b = '0; vld_b = 1'b0; end
    else   begin in_a = '0; vld_a = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; fails = 0;
    vld_a = 1'b0; vld_b = 1'b0;
    in_a = '0; in_b = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_a", 32'(wb_a), 32'd0);
    chk("reset_rdata_b", rdata_b, 32'd0);
    chk("reset_stall_b", 32'(stall_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Single-cycle memory: store/load, wrap, collision, branch.
    issue(0, 2'b00, 0, 1, 0, 0, 32'h10,  32'hDEADBEEF, 5'd0, 0, 32'h0,        0, 0);
    issue(0, 2'b11, 1, 0, 0, 0, 32'h10,  32'h0,        5'd4, 1, 32'hDEADBEEF, 0, 0);
    issue(0, 2'b00, 0, 1, 0, 0, 32'h400, 32'h1,        5'd0, 0, 32'h0,        0, 0);
    issue(0, 2'b11, 1, 0, 0, 0, 32'h0,   32'h0,        5'd7, 1, 32'h1,        0, 0);
    issue(0, 2'b10, 1, 1, 0, 0, 32'h0,   32'h2,        5'd8, 1, 32'h1,        0, 0);
    issue(0, 2'b11, 1, 0, 0, 0, 32'h3,   32'h0,        5'd9, 1, 32'h2,        0, 0);
    issue(0, 2'b10, 0, 0, 1, 1, 32'h5,   32'h0,        5'd1, 0, 32'h0,        0, 1);
    issue(0, 2'b11, 0, 0, 0, 0, 32'h44,  32'h0,        5'd9, 0, 32'h0,        0, 0);

    // Asynchronous reset mid-cycle with a live branch on the inputs.
    in_a.wb = 2'b11; in_a.dest = 5'd9; in_a.br = 1'b1; in_a.z = 1'b1;
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    #1;
    chk("async_rst_wb", 32'(wb_a), 32'd0);
    chk("async_rst_rdata", rdata_a, 32'd0);
    chk("async_rst_alu", alu_a, 32'd0);
    chk("async_rst_wreg", 32'(wreg_a), 32'd0);
    chk("async_rst_stall", 32'(stall_a), 32'd0);
    chk("async_rst_pcsrc", 32'(pcsrc_a), 32'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b0; in_a = '0;

    // Three wait states.
    issue(1, 2'b00, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 32'h0,        3, 0);
    issue(1, 2'b11, 1, 0, 0, 0, 32'h10, 32'h0,        5'd4, 1, 32'hDEADBEEF, 3, 0);
    issue(1, 2'b10, 0, 0, 0, 0, 32'h77, 32'h0,        5'd3, 0, 32'h0,        0, 0);
    issue(1, 2'b00, 0, 0, 1, 1, 32'h8,  32'h0,        5'd0, 0, 32'h0,        0, 1);
    issue(1, 2'b00, 0, 0, 1, 0, 32'h8,  32'h0,        5'd0, 0, 32'h0,        0, 0);
    issue(1, 2'b00, 0, 1, 0, 0, 32'h20, 32'h55,       5'd0, 0, 32'h0,        3, 0);

    // Store aborted by reset in its second stall cycle must never land.
    in_b.wr = 1'b1; in_b.addr = 32'h20; in_b.wdata = 32'hAA;
    @(negedge clk);
    chk("abort_first_stall", 32'(stall_b), 32'd1);
    @(posedge clk);
    #3;
    chk("abort_second_stall", 32'(stall_b), 32'd1);
    rst_b = 1'b1;
    #1;
    chk("abort_stall_drop", 32'(stall_b), 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b0; in_b = '0;
    issue(1, 2'b11, 1, 0, 0, 0, 32'h20, 32'h0, 5'd6, 1, 32'h55, 3, 0);

    repeat (3) @(negedge clk);
    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
